level_tile_rom: RTL and testbench



---
 rtl/level_pkg.sv | 64 ++++++
 rtl/tile_index.sv | 19 +
 rtl/level_tile_rom.sv | 39 +++
 tb/tb_level_tile_rom.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared playfield constants and the fixed per-room collision maps.
// Used by the tile ROM, the renderer and the player movement logic.
package level_pkg;

  localparam int unsigned TILE_SHIFT = 5;
  localparam int unsigned GRID_COLS  = 20;
  localparam int unsigned GRID_ROWS  = 15;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;

  // map[row][col] = 1 means wall.
  typedef logic [14:0][19:0] room_map_t;

  // Border walls, with optional 2-tile doorways and the twin interior blocks.
  function automatic room_map_t build_room(input logic door_n, input logic door_s,
                                           input logic door_e, input logic door_w,
                                           input logic blocks);
    room_map_t m;
    m = '0;
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        if (r == 0 || r == 14 || c == 0 || c == 19) m[4'(r)][5'(c)] = 1'b1;
      end
    end
    if (door_n) begin
      m[4'd0][5'd9]  = 1'b0;
      m[4'd0][5'd10] = 1'b0;
    end
    if (door_s) begin
      m[4'd14][5'd9]  = 1'b0;
      m[4'd14][5'd10] = 1'b0;
    end
    if (door_w) begin
      m[4'd7][5'd0] = 1'b0;
      m[4'd8][5'd0] = 1'b0;
    end
    if (door_e) begin
      m[4'd7][5'd19] = 1'b0;
      m[4'd8][5'd19] = 1'b0;
    end
    if (blocks) begin
      for (int r = 5; r <= 9; r++) begin
        m[4'(r)][5'd5]  = 1'b1;
        m[4'(r)][5'd6]  = 1'b1;
        m[4'(r)][5'd13] = 1'b1;
        m[4'(r)][5'd14] = 1'b1;
      end
    end
    return m;
  endfunction

  //                                     N     S     E     W     blocks
  localparam room_map_t ROOM_MAPS [0:7] = '{
    build_room(1'b1, 1'b1, 1'b0, 1'b0, 1'b0),
    build_room(1'b1, 1'b1, 1'b1, 1'b1, 1'b0),
    build_room(1'b0, 1'b0, 1'b1, 1'b1, 1'b0),
    build_room(1'b0, 1'b1, 1'b0, 1'b0, 1'b1),
    build_room(1'b1, 1'b0, 1'b0, 1'b0, 1'b0),
    build_room(1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
    build_room(1'b0, 1'b0, 1'b0, 1'b0, 1'b0),
    build_room(1'b0, 1'b0, 1'b0, 1'b0, 1'b0)
  };

endpackage

// File: rtl/tile_index.sv
// Maps a screen pixel to its 32x32 tile column/row and flags on-screen pixels.
module tile_index
  import level_pkg::*;
(
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [4:0] col,
  output logic [3:0] row,
  output logic       in_range
);

  always_comb begin
    col      = DrawX[9:5];
    // Rows only reach 14 on screen; DrawY[9] is set only off-screen.
    row      = DrawY[8:5];
    in_range = (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  end

endmodule

// File: rtl/level_tile_rom.sv
// Wall/floor lookup for a pixel in the selected room, with a registered copy.
module level_tile_rom
  import level_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [2:0] room,
  output logic       bg_type,
  output logic       bg_type_q
);

  logic [4:0] col;
  logic [3:0] row;
  logic       in_range;
  room_map_t  cur_map;

  tile_index u_tile_index (
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .col      (col),
    .row      (row),
    .in_range (in_range)
  );

  // Off-screen reads as floor so corner probes can leave through doorways.
  always_comb begin
    cur_map = ROOM_MAPS[room];
    bg_type = 1'b0;
    if (in_range) bg_type = cur_map[row][col];
  end

  always_ff @(posedge Clk) begin
    if (Reset) bg_type_q <= 1'b0;
    else       bg_type_q <= bg_type;
  end

endmodule

// File: tb/tb_level_tile_rom.sv
// Directed-vector bench for level_tile_rom: map lookups plus registered-path sequences.
module tb_level_tile_rom;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [2:0] room;
  logic       bg_type;
  logic       bg_type_q;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int unsigned x;
    int unsigned y;
    int unsigned rm;
    logic        exp;
  } vec_t;

  level_tile_rom dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .room      (room),
    .bg_type   (bg_type),
    .bg_type_q (bg_type_q)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs[$];
    Reset = 1'b1;
    DrawX = '0;
    DrawY = '0;
    room  = '0;

    // Room 0
    vecs.push_back('{0, 0, 0, 1'b1});
    vecs.push_back('{320, 240, 0, 1'b0});
    vecs.push_back('{0, 240, 0, 1'b1});
    vecs.push_back('{304, 0, 0, 1'b0});
    vecs.push_back('{639, 240, 0, 1'b1});
    vecs.push_back('{31, 0, 0, 1'b1});
    vecs.push_back('{32, 32, 0, 1'b0});
    // Room 1
    vecs.push_back('{639, 240, 1, 1'b0});
    vecs.push_back('{0, 230, 1, 1'b0});
    vecs.push_back('{639, 200, 1, 1'b1});
    vecs.push_back('{352, 479, 1, 1'b1});
    vecs.push_back('{351, 479, 1, 1'b0});
    // Room 2
    vecs.push_back('{0, 240, 2, 1'b0});
    vecs.push_back('{639, 272, 2, 1'b0});
    vecs.push_back('{304, 0, 2, 1'b1});
    vecs.push_back('{320, 479, 2, 1'b1});
    // Room 3
    vecs.push_back('{160, 160, 3, 1'b1});
    vecs.push_back('{159, 160, 3, 1'b0});
    vecs.push_back('{448, 300, 3, 1'b1});
    vecs.push_back('{304, 10, 3, 1'b1});
    vecs.push_back('{304, 479, 3, 1'b0});
    vecs.push_back('{224, 320, 3, 1'b0});
    // Room 4
    vecs.push_back('{320, 0, 4, 1'b0});
    vecs.push_back('{304, 479, 4, 1'b1});
    vecs.push_back('{0, 240, 4, 1'b1});
    // Rooms 5-7
    for (int r = 5; r < 8; r++) begin
      vecs.push_back('{320, 470, r, 1'b1});
      vecs.push_back('{5, 240, r, 1'b1});
      vecs.push_back('{320, 240, r, 1'b0});
    end
    // Off-screen in every room
    for (int r = 0; r < 8; r++) begin
      vecs.push_back('{642, 240, r, 1'b0});
      vecs.push_back('{320, 500, r, 1'b0});
      vecs.push_back('{1023, 1023, r, 1'b0});
    end

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    for (int i = 0; i < vecs.size(); i++) begin
      DrawX = 10'(vecs[i].x);
      DrawY = 10'(vecs[i].y);
      room  = 3'(vecs[i].rm);
      #1;
      check($sformatf("vec%0d r%0d (%0d,%0d)", i, vecs[i].rm, vecs[i].x, vecs[i].y),
            bg_type, vecs[i].exp);
    end

    // Registered path: reset hold, release, pixel change.
    @(negedge Clk);
    Reset = 1'b1;
    DrawX = 10'd0;
    DrawY = 10'd0;
    room  = 3'd0;
    @(posedge Clk); #1;
    check("q_in_reset", bg_type_q, 1'b0);
    check("comb_during_reset", bg_type, 1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("q_after_release", bg_type_q, 1'b1);
    @(negedge Clk);
    DrawX = 10'd320;
    DrawY = 10'd240;
    #1;
    check("comb_fall_now", bg_type, 1'b0);
    check("q_holds_old", bg_type_q, 1'b1);
    @(posedge Clk); #1;
    check("q_fall_next", bg_type_q, 1'b0);

    // Room change: (0,240) is wall in room 0, W doorway in room 1.
    @(negedge Clk);
    DrawX = 10'd0;
    DrawY = 10'd240;
    room  = 3'd0;
    @(posedge Clk); #1;
    check("q_room0_wall", bg_type_q, 1'b1);
    @(negedge Clk);
    room = 3'd1;
    #1;
    check("comb_room1_door", bg_type, 1'b0);
    check("q_room_lag", bg_type_q, 1'b1);
    @(posedge Clk); #1;
    check("q_room1_door", bg_type_q, 1'b0);

    // Synchronous reset clears a set register.
    @(negedge Clk);
    room = 3'd0;
    @(posedge Clk); #1;
    check("q_set_again", bg_type_q, 1'b1);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("q_no_async_clear", bg_type_q, 1'b1);
    @(posedge Clk); #1;
    check("q_sync_clear", bg_type_q, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
